// File: rtl/mmuart_xcvr.sv
`default_nettype none
// ============================================================================
// mmuart_xcvr : full-duplex UART transceiver, shared baud tick, optional parity
// Revision    : 1.0
// ============================================================================
module mmuart_xcvr #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DIV_W-1:0]     divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP1  = 3'd4;
  localparam logic [2:0] TX_STOP2  = 3'd5;

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;

  assign tick = (baud_cnt == '0);

  // Divisor is only looked at on reload, so a change lands on the next tick period
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      baud_cnt <= '0;
    else if (tick)
      baud_cnt <= (divisor == '0) ? '0 : divisor - DIV_ONE;
    else
      baud_cnt <= baud_cnt - DIV_ONE;
  end

  // ---------------- receiver ----------------
  logic                 rx_meta, rx_sync;
  logic [2:0]           rx_state;
  logic [OS_W-1:0]      rx_os;
  logic [BC_W-1:0]      rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_par, rx_pen, rx_podd, rx_perr_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state      <= RX_IDLE;
      rx_os         <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      rx_pen        <= 1'b0;
      rx_podd       <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rx_sync) begin
              rx_state <= RX_START;
              rx_os    <= '0;
              rx_pen   <= parity_mode[0] ^ parity_mode[1];
              rx_podd  <= (parity_mode == 2'b10);
            end
          end
          RX_START: begin
            if (rx_os == OS_HALF) begin
              rx_os <= '0;
              if (rx_sync) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_state  <= RX_DATA;
                rx_bit    <= '0;
                rx_par    <= 1'b0;
                rx_perr_q <= 1'b0;
              end
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_os == OS_LAST) begin
              rx_os  <= '0;
              rx_sh  <= {rx_sync, rx_sh[DATA_BITS-1:1]};
              rx_par <= rx_par ^ rx_sync;
              if (rx_bit == BIT_LAST)
                rx_state <= rx_pen ? RX_PARITY : RX_STOP;
              else
                rx_bit <= rx_bit + 1'b1;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          RX_PARITY: begin
            if (rx_os == OS_LAST) begin
              rx_os     <= '0;
              rx_perr_q <= rx_sync ^ rx_par ^ rx_podd;
              rx_state  <= RX_STOP;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          default: begin
            // Only the first stop bit is checked; a second one just looks like idle
            if (rx_os == OS_LAST) begin
              rx_os         <= '0;
              rx_data       <= rx_sh;
              rx_done       <= 1'b1;
              rx_frame_err  <= !rx_sync;
              rx_parity_err <= rx_pen & rx_perr_q;
              rx_state      <= RX_IDLE;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- transmitter ----------------
  logic [2:0]           tx_state;
  logic [OS_W-1:0]      tx_os;
  logic [BC_W-1:0]      tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_pbit, tx_pen, tx_two, tx_armed;
  logic                 tx_last;

  assign tx_last = (tx_state == TX_STOP2) || ((tx_state == TX_STOP1) && !tx_two);

  // tx_armed marks that the start bit has been put on the line at the first tick
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_pbit  <= 1'b0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_armed <= 1'b0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (tx_wr) begin
          tx_sh    <= tx_data;
          tx_pbit  <= (^tx_data) ^ (parity_mode == 2'b10);
          tx_pen   <= parity_mode[0] ^ parity_mode[1];
          tx_two   <= two_stop;
          tx_armed <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= TX_START;
        end
      end else if (tick) begin
        if (!tx_armed) begin
          tx_armed <= 1'b1;
          uart_tx  <= 1'b0;
          tx_os    <= '0;
        end else if (tx_os != OS_LAST) begin
          tx_os <= tx_os + 1'b1;
        end else begin
          tx_os <= '0;
          if (tx_last) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            uart_tx  <= 1'b1;
          end else begin
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx_bit   <= '0;
                uart_tx  <= tx_sh[0];
              end
              TX_DATA: begin
                if (tx_bit == BIT_LAST) begin
                  tx_state <= tx_pen ? TX_PARITY : TX_STOP1;
                  uart_tx  <= tx_pen ? tx_pbit : 1'b1;
                end else begin
                  tx_bit  <= tx_bit + 1'b1;
                  tx_sh   <= tx_sh >> 1;
                  uart_tx <= tx_sh[1];
                end
              end
              TX_PARITY: begin
                tx_state <= TX_STOP1;
                uart_tx  <= 1'b1;
              end
              default: begin
                tx_state <= TX_STOP2;
                uart_tx  <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mmuart_xcvr.md
MMUART_XCVR -- requirements
Module: mmuart_xcvr

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, meaning baud ticks per bit, legal values 8 or 16.
REQ-003 SHALL provide parameter DIV_W, default 16, meaning divisor width.
REQ-004 SHALL provide one clock and one reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL provide these ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  async active-low reset
- uart_rx  in  1  serial input (asynchronous to sys_clk)
- uart_tx  out  1  serial output
- divisor  in  DIV_W  sys_clk cycles per baud tick
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  TX sends 2 stop bits when 1
- rx_data  out  DATA_BITS  last received word
- rx_done  out  1  one-cycle pulse, word valid
- rx_frame_err  out  1  stop bit sampled low; valid with rx_done
- rx_parity_err  out  1  parity mismatch; valid with rx_done
- tx_data  in  DATA_BITS  word to send
- tx_wr  in  1  send request
- tx_busy  out  1  transmitter active
- tx_done  out  1  one-cycle pulse, frame finished

Function
REQ-006 SHALL generate baud tick from a DIV_W counter:
- tick when counter==0, then reload divisor-1; otherwise decrement
- divisor==0 SHALL behave as divisor==1, i.e. a tick every cycle
- a divisor change takes effect at the next reload only
REQ-007 SHALL synchronise uart_rx through two flops before any use; synchronised idle level is 1.
REQ-008 RX SHALL implement states IDLE, START, DATA, PARITY, STOP, sampling only on baud ticks.
REQ-009 RX IDLE->START SHALL occur on the first tick with synchronised rx==0; a tick counter then starts at 0.
REQ-010 In START, RX SHALL sample at tick count OVERSAMPLE/2-1:
- sample 1: return to IDLE (glitch) with no pulse and no error
- sample 0: go to DATA; subsequent samples every OVERSAMPLE ticks (mid-bit)
REQ-011 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY if parity is enabled, else STOP.
REQ-012 PARITY SHALL compare the sampled bit to the XOR of the data (even) or its inverse (odd).
REQ-013 STOP SHALL sample one stop bit, regardless of two_stop, then in the same cycle:
- load rx_data
- pulse rx_done for exactly one sys_clk cycle
- set rx_frame_err = !stop sample and rx_parity_err per REQ-012 (0 when parity is off)
- return to IDLE
REQ-014 rx_data, rx_frame_err and rx_parity_err SHALL hold until the next rx_done.
REQ-015 TX SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, each bit lasting OVERSAMPLE ticks.
REQ-016 TX in IDLE with tx_wr=1 SHALL, on the next clock edge:
- latch tx_data, parity_mode and two_stop
- assert tx_busy
- enter START
uart_tx SHALL go to 0 at the first tick after entry.
REQ-017 tx_wr while tx_busy=1 SHALL be ignored; changes to tx_data, parity_mode or two_stop mid-frame SHALL NOT affect the current frame.
REQ-018 TX SHALL send:
- data LSB first
- parity (REQ-012 rule) when enabled
- STOP1, then STOP2 only if latched two_stop=1
- uart_tx=1 during stop bits and in IDLE
REQ-019 At the end of the final stop bit, TX SHALL pulse tx_done for one cycle, deassert tx_busy in the same cycle and return to IDLE; tx_wr in that same cycle SHALL be ignored.
REQ-020 RX and TX SHALL operate fully independently and concurrently.

Reset
REQ-021 SHALL apply these values asynchronously on sys_rst_n=0:
- uart_tx=1, tx_busy=0, tx_done=0
- rx_done=0, rx_data=0, rx_frame_err=0, rx_parity_err=0
- both FSMs in IDLE; baud counter=0; synchroniser flops=1
REQ-022 Reset asserted mid-frame SHALL abort both frames with no rx_done or tx_done pulse.

Verification
REQ-023 divisor=3, OVERSAMPLE=16, 8N1, tx_wr with tx_data=8'hA5 -> uart_tx start bit then 1,0,1,0,0,1,0,1 then stop bit, each bit 48 clocks; tx_done after 480 clocks; tx_busy high throughout.
REQ-024 Loopback uart_tx->uart_rx, parity_mode=10, tx_data=8'h3C -> rx_done pulse with rx_data=8'h3C, rx_parity_err=0, rx_frame_err=0.
REQ-025 Drive frame 8'h55 with the stop bit forced low -> rx_done with rx_data=8'h55 and rx_frame_err=1.
REQ-026 Drive a 0 pulse on uart_rx of 4 baud ticks while RX is IDLE -> no rx_done; a following valid frame 8'h81 is received correctly.
REQ-027 two_stop=1: tx_wr repeated at cycle +10 with a new value -> ignored; first frame is 11 bits long; reset pulse mid-frame -> uart_tx=1 immediately and no tx_done.
REQ-028 DATA_BITS=5, divisor=0 -> tick every clock; tx_data=5'h13 is sent in 5 data bits and received back as 5'h13.
